multicycle_ctrl: RTL and testbench
==================================

// Module: multicycle_ctrl
// PURPOSE
//  Multi-cycle sequencer for the 16-bit CPU datapath. It replaces single-cycle decode with a state machine FETCH/DECODE/EXEC/MEM/WB.
//  It drives the existing datapath strobes (RegDst, AluSrc, AluOp, MemToReg, RegWrite, MemRead, MemWrite, Shift) one phase at a time.
//  It waits on a shared-memory ready handshake and halts on an illegal opcode or a memory timeout.
// PARAMETERS
//  MEM_WAIT_MAX  15  max consecutive cycles waiting for MemReady in FETCH or MEM before entering HALT (1..255)
// PORTS
//  Clock       in   1  rising-edge clock; single clock domain
//  Reset       in   1  synchronous, active-low reset
//  OPCODE      in   4  instruction bits [15:12] from the instruction register
//  Zero        in   1  ALU zero flag
//  MemReady    in   1  memory completes the current read/write this cycle
//  PCWrite     out  1  load PC this cycle
//  PCSrc       out  1  0 = PC+2, 1 = branch target
//  IRWrite     out  1  load instruction register
//  IorD        out  1  memory address select: 0 = PC, 1 = ALU result
//  MemRead     out  1  memory read request
//  MemWrite    out  1  memory write request
//  MemToReg    out  1  write-back source: 1 = memory data
//  RegDst      out  1  1 = rd, 0 = rt destination
//  RegWrite    out  1  register-file write enable
//  AluSrc      out  1  1 = immediate operand
//  AluOp       out  2  ALU op class: 00 add, 01 sub/compare, 10 funct, 11 immediate
//  Shift       out  1  shifter path select
//  InstrDone   out  1  one-cycle pulse in the last cycle of each instruction
//  Halted      out  1  high in HALT
//  HaltCause   out  2  00 none, 01 illegal opcode, 10 memory timeout
//  State       out  3  current state, for debug
// BEHAVIOUR
//  - State encoding: FETCH=0, DECODE=1, EXEC=2, MEM=3, WB=4, HALT=7.
//  - Reset=0 at a clock edge:
//    - state<=FETCH; op_q<=0; wait counter<=0; HaltCause<=00.
//    - While Reset=0, every strobe output is combinationally forced to 0.
//  - FETCH: IorD=0, MemRead=1.
//    - If MemReady=1: IRWrite=1, PCWrite=1, PCSrc=0; next state DECODE.
//    - Otherwise stay in FETCH and increment the wait counter.
//  - DECODE: no strobes; op_q<=OPCODE.
//    - Legal opcodes {0000,0001,0010,1001,1010,1011,1100,1101,1111} go to EXEC.
//    - Any other opcode goes to HALT with HaltCause=01.
//  - EXEC: drive per op_q.
//    - R-type 0000/0001: AluSrc=0, AluOp=10. Shift 0010: AluOp=10, Shift=1, AluSrc=0.
//    - 1001/1010/1011: AluSrc=1, AluOp=11. LW/SW: AluSrc=1, AluOp=00.
//    - BEQ: AluSrc=0, AluOp=01. If Zero=1 then PCWrite=1 and PCSrc=1. InstrDone=1; next FETCH.
//    - R, I and shift types go to WB. LW/SW go to MEM.
//  - MEM: IorD=1 and AluOp/AluSrc held at the EXEC values; MemRead=1 for LW, MemWrite=1 for SW.
//    - On MemReady=1: SW gives InstrDone=1 and goes to FETCH; LW goes to WB.
//    - Otherwise stay in MEM and increment the wait counter.
//  - WB: RegWrite=1 for exactly one cycle; InstrDone=1; next FETCH.
//    - RegDst=1 for 0000/0001/0010, else 0. MemToReg=1 only for LW.
//  - Wait counter: cleared on every state change.
//    - If it reaches MEM_WAIT_MAX while MemReady=0, go to HALT with HaltCause=10.
//    - MemReady=1 in that same cycle wins: the transfer completes and there is no halt.
//  - HALT: all strobes 0, Halted=1, HaltCause held. Exit only through Reset.
//  - Strobes are Moore outputs of state/op_q, except PCWrite, IRWrite and InstrDone, which are also gated by MemReady/Zero.
//  - Latency with MemReady tied to 1:
//    - BEQ 3 cycles; R/I/shift 4 cycles; SW 4 cycles; LW 5 cycles.
//    - Each cycle MemReady=0 in FETCH or MEM adds one cycle.
//  - OPCODE changes outside DECODE have no effect; op_q is the only source used after DECODE.
//  - Reset asserted mid-MEM:
//    - The write strobe drops in that same cycle; there is no partial write-back.
//    - The next cycle after reset release is FETCH.
// TESTING
//  - Reset=0 for 2 cycles, then 1, MemReady=1, OPCODE=0001: State sequence 0,1,2,4,0. RegWrite=1 and RegDst=1 only in WB. InstrDone pulses once.
//  - OPCODE=1100, MemReady=1: State sequence 0,1,2,3,4. MEM has IorD=1 and MemRead=1. WB has MemToReg=1 and RegWrite=1. 5 cycles total.
//  - OPCODE=1111, Zero=1, then repeat with Zero=0: EXEC PCWrite=1/PCSrc=1 versus PCWrite=0. Both take 3 cycles. RegWrite is never asserted.
//  - OPCODE=1101, MemReady low for 3 cycles in MEM: MemWrite held 4 cycles. InstrDone appears on the 4th. Next state FETCH.
//  - OPCODE=0111: DECODE leads to HALT with Halted=1 and HaltCause=01. Only Reset=0 returns State to 0.
//  - MEM_WAIT_MAX=4, MemReady=0 in FETCH: HALT with HaltCause=10 after 4 wait cycles. Repeat with MemReady=1 on the 4th cycle: no halt, DECODE follows.

Source files
------------

// File: rtl/multicycle_ctrl.sv
// Multi-cycle FETCH/DECODE/EXEC/MEM/WB sequencer for the 16-bit CPU datapath.
// Drives datapath strobes one phase at a time and halts on illegal opcodes or memory timeouts.
module multicycle_ctrl #(
  parameter int unsigned MEM_WAIT_MAX = 15
) (
  input  logic       Clock,
  input  logic       Reset,
  input  logic [3:0] OPCODE,
  input  logic       Zero,
  input  logic       MemReady,
  output logic       PCWrite,
  output logic       PCSrc,
  output logic       IRWrite,
  output logic       IorD,
  output logic       MemRead,
  output logic       MemWrite,
  output logic       MemToReg,
  output logic       RegDst,
  output logic       RegWrite,
  output logic       AluSrc,
  output logic [1:0] AluOp,
  output logic       Shift,
  output logic       InstrDone,
  output logic       Halted,
  output logic [1:0] HaltCause,
  output logic [2:0] State
);

  typedef enum logic [2:0] {
    S_FETCH  = 3'd0,
    S_DECODE = 3'd1,
    S_EXEC   = 3'd2,
    S_MEM    = 3'd3,
    S_WB     = 3'd4,
    S_HALT   = 3'd7
  } state_t;

  localparam logic [3:0] OP_R0  = 4'b0000;
  localparam logic [3:0] OP_R1  = 4'b0001;
  localparam logic [3:0] OP_SH  = 4'b0010;
  localparam logic [3:0] OP_I0  = 4'b1001;
  localparam logic [3:0] OP_I1  = 4'b1010;
  localparam logic [3:0] OP_I2  = 4'b1011;
  localparam logic [3:0] OP_LW  = 4'b1100;
  localparam logic [3:0] OP_SW  = 4'b1101;
  localparam logic [3:0] OP_BEQ = 4'b1111;

  localparam logic [7:0] WAIT_LIMIT = 8'(MEM_WAIT_MAX);

  localparam logic [1:0] CAUSE_NONE    = 2'b00;
  localparam logic [1:0] CAUSE_ILLEGAL = 2'b01;
  localparam logic [1:0] CAUSE_TIMEOUT = 2'b10;

  state_t     state_q, state_d;
  logic [3:0] op_q, op_d;
  logic [7:0] wait_cnt_q, wait_cnt_d;
  logic [1:0] halt_cause_q, halt_cause_d;
  logic       wait_hit;
  logic       op_legal;
  logic       op_is_mem;

  // The current not-ready cycle is the last one allowed before timing out.
  assign wait_hit  = (wait_cnt_q == (WAIT_LIMIT - 8'd1));
  assign op_is_mem = (op_q == OP_LW) || (op_q == OP_SW);

  always_comb begin
    case (OPCODE)
      OP_R0, OP_R1, OP_SH, OP_I0, OP_I1, OP_I2, OP_LW, OP_SW, OP_BEQ: op_legal = 1'b1;
      default: op_legal = 1'b0;
    endcase
  end

  always_ff @(posedge Clock) begin
    if (!Reset) begin
      state_q      <= S_FETCH;
      op_q         <= 4'b0000;
      wait_cnt_q   <= 8'd0;
      halt_cause_q <= CAUSE_NONE;
    end else begin
      state_q      <= state_d;
      op_q         <= op_d;
      wait_cnt_q   <= wait_cnt_d;
      halt_cause_q <= halt_cause_d;
    end
  end

  always_comb begin
    state_d      = state_q;
    op_d         = op_q;
    wait_cnt_d   = wait_cnt_q;
    halt_cause_d = halt_cause_q;
    case (state_q)
      S_FETCH: begin
        if (MemReady) begin
          state_d = S_DECODE;
        end else if (wait_hit) begin
          state_d      = S_HALT;
          halt_cause_d = CAUSE_TIMEOUT;
        end else begin
          wait_cnt_d = wait_cnt_q + 8'd1;
        end
      end
      S_DECODE: begin
        op_d = OPCODE;
        if (op_legal) begin
          state_d = S_EXEC;
        end else begin
          state_d      = S_HALT;
          halt_cause_d = CAUSE_ILLEGAL;
        end
      end
      S_EXEC: begin
        if (op_q == OP_BEQ)  state_d = S_FETCH;
        else if (op_is_mem)  state_d = S_MEM;
        else                 state_d = S_WB;
      end
      S_MEM: begin
        if (MemReady) begin
          state_d = (op_q == OP_SW) ? S_FETCH : S_WB;
        end else if (wait_hit) begin
          state_d      = S_HALT;
          halt_cause_d = CAUSE_TIMEOUT;
        end else begin
          wait_cnt_d = wait_cnt_q + 8'd1;
        end
      end
      S_WB:    state_d = S_FETCH;
      S_HALT:  state_d = S_HALT;
      default: state_d = S_FETCH;
    endcase
    if (state_d != state_q) wait_cnt_d = 8'd0;
  end

  // Strobes follow state/op_q; only PCWrite, IRWrite and InstrDone look at MemReady/Zero.
  always_comb begin
    PCWrite   = 1'b0;
    PCSrc     = 1'b0;
    IRWrite   = 1'b0;
    IorD      = 1'b0;
    MemRead   = 1'b0;
    MemWrite  = 1'b0;
    MemToReg  = 1'b0;
    RegDst    = 1'b0;
    RegWrite  = 1'b0;
    AluSrc    = 1'b0;
    AluOp     = 2'b00;
    Shift     = 1'b0;
    InstrDone = 1'b0;
    case (state_q)
      S_FETCH: begin
        MemRead = 1'b1;
        IRWrite = MemReady;
        PCWrite = MemReady;
      end
      S_EXEC: begin
        case (op_q)
          OP_R0, OP_R1: AluOp = 2'b10;
          OP_SH: begin
            AluOp = 2'b10;
            Shift = 1'b1;
          end
          OP_I0, OP_I1, OP_I2: begin
            AluSrc = 1'b1;
            AluOp  = 2'b11;
          end
          OP_LW, OP_SW: AluSrc = 1'b1;
          OP_BEQ: begin
            AluOp     = 2'b01;
            PCSrc     = 1'b1;
            PCWrite   = Zero;
            InstrDone = 1'b1;
          end
          default: ;
        endcase
      end
      S_MEM: begin
        IorD      = 1'b1;
        AluSrc    = 1'b1;
        MemRead   = (op_q == OP_LW);
        MemWrite  = (op_q == OP_SW);
        InstrDone = (op_q == OP_SW) && MemReady;
      end
      S_WB: begin
        RegWrite  = 1'b1;
        InstrDone = 1'b1;
        RegDst    = (op_q == OP_R0) || (op_q == OP_R1) || (op_q == OP_SH);
        MemToReg  = (op_q == OP_LW);
      end
      default: ;
    endcase
    if (!Reset) begin
      PCWrite   = 1'b0;
      PCSrc     = 1'b0;
      IRWrite   = 1'b0;
      IorD      = 1'b0;
      MemRead   = 1'b0;
      MemWrite  = 1'b0;
      MemToReg  = 1'b0;
      RegDst    = 1'b0;
      RegWrite  = 1'b0;
      AluSrc    = 1'b0;
      AluOp     = 2'b00;
      Shift     = 1'b0;
      InstrDone = 1'b0;
    end
  end

  assign Halted    = (state_q == S_HALT);
  assign HaltCause = halt_cause_q;
  assign State     = state_q;

endmodule

// File: tb/tb_multicycle_ctrl.sv
// Scoreboard bench for multicycle_ctrl: per-cycle stimulus and expected outputs are queued,
// then replayed one clock at a time and compared against the DUT.
module tb_multicycle_ctrl;

  localparam int WAIT_MAX = 4;

  localparam logic [2:0] ST_FETCH  = 3'd0;
  localparam logic [2:0] ST_DECODE = 3'd1;
  localparam logic [2:0] ST_EXEC   = 3'd2;
  localparam logic [2:0] ST_MEM    = 3'd3;
  localparam logic [2:0] ST_WB     = 3'd4;
  localparam logic [2:0] ST_HALT   = 3'd7;

  logic       clk = 1'b0;
  logic       reset_n;
  logic [3:0] opcode;
  logic       zero;
  logic       mem_ready;
  logic       pc_write, pc_src, ir_write, i_or_d, mem_read, mem_write;
  logic       mem_to_reg, reg_dst, reg_write, alu_src, shift, instr_done, halted;
  logic [1:0] alu_op, halt_cause;
  logic [2:0] state;
  logic [19:0] observed;

  int checks = 0;
  int errors = 0;
  int cycle_no = 0;

  typedef struct packed {
    logic        rst;
    logic [3:0]  opc;
    logic        mr;
    logic        z;
    logic [19:0] exp;
  } cyc_t;

  cyc_t  stim_q[$];
  string tag_q[$];

  multicycle_ctrl #(.MEM_WAIT_MAX(WAIT_MAX)) dut (
    .Clock(clk), .Reset(reset_n), .OPCODE(opcode), .Zero(zero), .MemReady(mem_ready),
    .PCWrite(pc_write), .PCSrc(pc_src), .IRWrite(ir_write), .IorD(i_or_d),
    .MemRead(mem_read), .MemWrite(mem_write), .MemToReg(mem_to_reg), .RegDst(reg_dst),
    .RegWrite(reg_write), .AluSrc(alu_src), .AluOp(alu_op), .Shift(shift),
    .InstrDone(instr_done), .Halted(halted), .HaltCause(halt_cause), .State(state)
  );

  always #5 clk = ~clk;

  assign observed = {state, pc_write, pc_src, ir_write, i_or_d, mem_read, mem_write,
                     mem_to_reg, reg_dst, reg_write, alu_src, alu_op, shift,
                     instr_done, halted, halt_cause};

  initial begin
    #2000000;
    $display("[TB] FAIL watchdog: simulation did not finish in time");
    $fatal(1, "[TB] watchdog expired");
  end

  function automatic logic legal(input logic [3:0] op);
    return op inside {4'b0000, 4'b0001, 4'b0010, 4'b1001, 4'b1010,
                      4'b1011, 4'b1100, 4'b1101, 4'b1111};
  endfunction

  function automatic logic [3:0] rnd_op();
    return 4'($urandom_range(0, 15));
  endfunction

  // Expected output vector for one cycle, in the same order as 'observed'.
  function automatic logic [19:0] model(input logic rst, input logic [2:0] st,
                                        input logic [3:0] op, input logic mr,
                                        input logic z, input logic [1:0] hc);
    logic pcw, pcs, irw, iord, mrd, mwr, m2r, rdst, rw, asrc, sh, idone;
    logic [1:0] aop;
    {pcw, pcs, irw, iord, mrd, mwr, m2r, rdst, rw, asrc, sh, idone} = '0;
    aop = 2'b00;
    if (st == ST_FETCH) begin
      mrd = 1'b1; irw = mr; pcw = mr;
    end else if (st == ST_EXEC) begin
      if (op == 4'b0000 || op == 4'b0001) aop = 2'b10;
      else if (op == 4'b0010) begin aop = 2'b10; sh = 1'b1; end
      else if (op inside {4'b1001, 4'b1010, 4'b1011}) begin asrc = 1'b1; aop = 2'b11; end
      else if (op == 4'b1100 || op == 4'b1101) asrc = 1'b1;
      else if (op == 4'b1111) begin aop = 2'b01; pcs = 1'b1; pcw = z; idone = 1'b1; end
    end else if (st == ST_MEM) begin
      iord = 1'b1; asrc = 1'b1;
      mrd = (op == 4'b1100); mwr = (op == 4'b1101);
      idone = (op == 4'b1101) && mr;
    end else if (st == ST_WB) begin
      rw = 1'b1; idone = 1'b1;
      rdst = (op == 4'b0000 || op == 4'b0001 || op == 4'b0010);
      m2r = (op == 4'b1100);
    end
    if (!rst) begin
      {pcw, pcs, irw, iord, mrd, mwr, m2r, rdst, rw, asrc, sh, idone} = '0;
      aop = 2'b00;
    end
    return {st, pcw, pcs, irw, iord, mrd, mwr, m2r, rdst, rw, asrc, aop, sh, idone,
            (st == ST_HALT), hc};
  endfunction

  task automatic push_cyc(input logic rst, input logic [3:0] opc, input logic mr,
                          input logic z, input logic [2:0] st, input logic [3:0] op,
                          input logic [1:0] hc);
    cyc_t r;
    r.rst = rst; r.opc = opc; r.mr = mr; r.z = z;
    r.exp = model(rst, st, op, mr, z, hc);
    stim_q.push_back(r);
    tag_q.push_back($sformatf("cyc%0d_op%b_st%0d", stim_q.size() + cycle_no, op, st));
  endtask

  // Queues one whole instruction with the given FETCH/MEM not-ready cycle counts.
  task automatic queue_instr(input logic [3:0] op, input logic z, input int fw, input int mw);
    for (int i = 0; i < fw; i++) begin
      push_cyc(1'b1, rnd_op(), 1'b0, z, ST_FETCH, op, 2'b00);
      if (i + 1 == WAIT_MAX) begin
        push_cyc(1'b1, rnd_op(), 1'($urandom_range(0, 1)), z, ST_HALT, op, 2'b10);
        return;
      end
    end
    push_cyc(1'b1, rnd_op(), 1'b1, z, ST_FETCH, op, 2'b00);
    push_cyc(1'b1, op, 1'($urandom_range(0, 1)), z, ST_DECODE, op, 2'b00);
    if (!legal(op)) begin
      push_cyc(1'b1, rnd_op(), 1'($urandom_range(0, 1)), z, ST_HALT, op, 2'b01);
      return;
    end
    push_cyc(1'b1, rnd_op(), 1'($urandom_range(0, 1)), z, ST_EXEC, op, 2'b00);
    if (op == 4'b1111) return;
    if (op == 4'b1100 || op == 4'b1101) begin
      for (int i = 0; i < mw; i++) begin
        push_cyc(1'b1, rnd_op(), 1'b0, z, ST_MEM, op, 2'b00);
        if (i + 1 == WAIT_MAX) begin
          push_cyc(1'b1, rnd_op(), 1'($urandom_range(0, 1)), z, ST_HALT, op, 2'b10);
          return;
        end
      end
      push_cyc(1'b1, rnd_op(), 1'b1, z, ST_MEM, op, 2'b00);
      if (op == 4'b1101) return;
    end
    push_cyc(1'b1, rnd_op(), 1'($urandom_range(0, 1)), z, ST_WB, op, 2'b00);
  endtask

  task automatic checkOutput(input string tag, input logic [19:0] act, input logic [19:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("[TB] FAIL %s: got %h expected %h", tag, act, exp);
    end
  endtask

  // Replays queued cycles: drive just after posedge, compare on the negedge.
  task automatic applyStimulus();
    cyc_t  r;
    string t;
    while (stim_q.size() > 0) begin
      r = stim_q.pop_front();
      t = tag_q.pop_front();
      reset_n   = r.rst;
      opcode    = r.opc;
      mem_ready = r.mr;
      zero      = r.z;
      @(negedge clk);
      checkOutput(t, observed, r.exp);
      cycle_no++;
      @(posedge clk);
      #1;
    end
  endtask

  initial begin
    reset_n = 1'b0; opcode = 4'b0000; zero = 1'b0; mem_ready = 1'b1;
    @(posedge clk);
    #1;
    push_cyc(1'b0, 4'b0001, 1'b1, 1'b0, ST_FETCH, 4'b0000, 2'b00);

    queue_instr(4'b0001, 1'b0, 0, 0);
    queue_instr(4'b1100, 1'b0, 0, 0);
    queue_instr(4'b1111, 1'b1, 0, 0);
    queue_instr(4'b1111, 1'b0, 0, 0);
    queue_instr(4'b1101, 1'b0, 0, 3);
    queue_instr(4'b0000, 1'b1, 2, 0);
    queue_instr(4'b0010, 1'b0, 0, 0);
    queue_instr(4'b1001, 1'b0, 0, 0);
    queue_instr(4'b1010, 1'b1, 1, 0);
    queue_instr(4'b1011, 1'b0, 0, 0);
    queue_instr(4'b1100, 1'b0, 3, 3);
    applyStimulus();
    $display("[TB] legal instruction mix done");

    queue_instr(4'b0111, 1'b0, 0, 0);
    push_cyc(1'b1, rnd_op(), 1'b1, 1'b1, ST_HALT, 4'b0111, 2'b01);
    push_cyc(1'b1, rnd_op(), 1'b0, 1'b0, ST_HALT, 4'b0111, 2'b01);
    push_cyc(1'b0, rnd_op(), 1'b1, 1'b0, ST_HALT, 4'b0111, 2'b01);

    queue_instr(4'b0001, 1'b0, 4, 0);
    push_cyc(1'b1, rnd_op(), 1'b1, 1'b0, ST_HALT, 4'b0001, 2'b10);
    push_cyc(1'b0, rnd_op(), 1'b1, 1'b0, ST_HALT, 4'b0001, 2'b10);

    queue_instr(4'b1100, 1'b0, 0, 4);
    push_cyc(1'b0, rnd_op(), 1'b0, 1'b0, ST_HALT, 4'b1100, 2'b10);

    push_cyc(1'b1, rnd_op(), 1'b1, 1'b0, ST_FETCH, 4'b1101, 2'b00);
    push_cyc(1'b1, 4'b1101, 1'b1, 1'b0, ST_DECODE, 4'b1101, 2'b00);
    push_cyc(1'b1, rnd_op(), 1'b1, 1'b0, ST_EXEC, 4'b1101, 2'b00);
    push_cyc(1'b0, rnd_op(), 1'b1, 1'b0, ST_MEM, 4'b1101, 2'b00);

    queue_instr(4'b1011, 1'b0, 0, 0);
    push_cyc(1'b1, rnd_op(), 1'b1, 1'b0, ST_FETCH, 4'b0000, 2'b00);
    applyStimulus();
    $display("[TB] halt and reset scenarios done");

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
